spec_global_history_reg: RTL and testbench
==========================================

# spec_global_history_reg

Speculative global history register with checkpoint repair for the branch predictor front end. Each decode-stage branch shifts its predicted direction into the history. A per-branch checkpoint queue then restores the correct history when the EX stage resolves a mispredicted branch. This block replaces the single-branch GHR and supports up to MAX_INFLIGHT unresolved branches, with a committed history kept alongside the speculative one.

## Interface
- BPRED_WIDTH, 9, history length in bits (≥2)
- MAX_INFLIGHT, 4, checkpoint queue depth, i.e. maximum number of unresolved branches (power of 2, ≥2)
- i_Clk  in  1  clock, all state updates on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_DEC_Is_Branch  in  1  branch instruction in DEC this cycle
- i_Prediction  in  1  predicted direction for the DEC branch (1 = taken)
- i_ALU_Branch_Valid  in  1  oldest in-flight branch resolves in EX this cycle
- i_ALU_Branch_Outcome  in  1  actual direction of the resolving branch
- i_Flush  in  1  pipeline flush (exception/redirect); discard all speculation
- o_Global_History  out  BPRED_WIDTH  speculative history used for prediction lookup
- o_Commit_History  out  BPRED_WIDTH  history of resolved branches only
- o_Full  out  1  queue holds MAX_INFLIGHT entries; DEC must stall branches
- o_Mispredict  out  1  one-cycle registered pulse, resolved branch was mispredicted
- o_Count  out  $clog2(MAX_INFLIGHT+1)  unresolved branches in queue
- o_Error  out  1  sticky: resolve with empty queue, or push while full

## Operation
- Each queue entry holds {pre-shift speculative history, predicted bit}. The queue is a circular FIFO with read/write pointers, and resolution is strictly oldest-first.
- Push happens when i_DEC_Is_Branch and not o_Full. Spec history becomes {hist[W-2:0], i_Prediction}, and the entry is written.
- Resolve happens when i_ALU_Branch_Valid and the queue is non-empty. The oldest entry is popped. Commit history becomes {commit[W-2:0], i_ALU_Branch_Outcome}.
  - Correct prediction: spec history is unchanged by the resolve.
  - Mispredict: spec history becomes {checkpoint[W-2:0], i_ALU_Branch_Outcome}. The queue is emptied, since all younger branches are wrong-path. o_Mispredict=1 next cycle.
- Simultaneous push and correct resolve: both take effect. Count is unchanged, and the spec shift uses i_Prediction.
- Simultaneous push and mispredict resolve: repair wins and the push is discarded (DEC branch is wrong-path). Count becomes 0.
- i_Flush: spec history becomes the commit history, including any same-cycle resolve. The queue is emptied. i_Flush overrides push and repair, but a same-cycle resolve still updates the commit history.
- Push while full: ignored, state unchanged, o_Error set.
- Resolve while empty: ignored, commit history unchanged, o_Error set.
- o_Full = (o_Count == MAX_INFLIGHT) and is combinational from o_Count.

## Timing
- Reset values: both histories 0, queue empty, o_Count 0, o_Full 0, o_Mispredict 0, o_Error 0.
- Reset is asynchronous. Asserting it mid-operation clears all state immediately, with no pending entries surviving.
- Push latency: o_Global_History reflects a DEC branch on the first edge after it is sampled. The next DEC branch sees the updated history.
- Repair latency: the corrected o_Global_History and o_Mispredict are both visible one cycle after the resolve edge.
- Pointer wrap-around at MAX_INFLIGHT must not corrupt entries. Count is tracked separately from the pointers, so full and empty are distinguishable.

## Configuration
- SPEC_GHR_STATS_EN defined: adds output o_Mispredict_Count [15:0]. It increments on every mispredict resolve, saturates at 16'hFFFF, and resets to 0.
- SPEC_GHR_STATS_EN not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then push predictions 1,0,1 over three cycles → o_Global_History=9'b000000101, o_Count=3, o_Commit_History=0.
- From that state, resolve the oldest with outcome 1 (correct) → spec history stays 9'b000000101, commit=9'b000000001, o_Count=2, o_Mispredict=0.
- Next, resolve with outcome 1 against prediction 0 → spec=9'b000000011 (checkpoint 9'b1 shifted with 1), o_Count=0, o_Mispredict pulses 1 for exactly one cycle.
- Push 4 branches (MAX_INFLIGHT=4) → o_Full=1. A 5th push leaves history unchanged and sets o_Error=1. A simultaneous push and correct resolve while full keeps o_Count=4 and shifts in the new prediction.
- Push 2 branches, then assert i_Flush → spec history equals the commit history, o_Count=0. Assert i_Reset asynchronously mid-sequence → all outputs 0 before the next clock edge.
- With SPEC_GHR_STATS_EN defined, 3 mispredicts → o_Mispredict_Count=3. A correct resolve does not increment the count.

Source files
------------

// File: rtl/spec_global_history_reg.sv
// Speculative global history register with a per-branch checkpoint queue for misprediction repair.
// Optional mispredict statistics counter enabled by defining SPEC_GHR_STATS_EN.
module spec_global_history_reg #(
  parameter int BPRED_WIDTH  = 9,
  parameter int MAX_INFLIGHT = 4,
  localparam int CW = $clog2(MAX_INFLIGHT + 1),
  localparam int PW = $clog2(MAX_INFLIGHT)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic                   i_Prediction,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  input  logic                   i_Flush,
  output logic [BPRED_WIDTH-1:0] o_Global_History,
  output logic [BPRED_WIDTH-1:0] o_Commit_History,
  output logic                   o_Full,
  output logic                   o_Mispredict,
  output logic [CW-1:0]          o_Count,
  output logic                   o_Error
`ifdef SPEC_GHR_STATS_EN
  ,
  output logic [15:0]            o_Mispredict_Count
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_INFLIGHT);

  logic [BPRED_WIDTH-1:0] spec_q, spec_d;
  logic [BPRED_WIDTH-1:0] commit_q, commit_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic                   mispredict_q, mispredict_d;
  logic                   error_q, error_d;

  // Each entry is {pre-shift speculative history, predicted bit}.
  logic [BPRED_WIDTH:0]   entry_mem [MAX_INFLIGHT];
  logic                   push_we;

  logic                   full;
  logic                   empty;
  logic                   resolve;
  logic                   push_ok;
  logic                   misp;
  logic [BPRED_WIDTH-1:0] ck_hist;
  logic                   ck_pred;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign ck_hist = entry_mem[rd_ptr_q][BPRED_WIDTH:1];
  assign ck_pred = entry_mem[rd_ptr_q][0];
  assign resolve = i_ALU_Branch_Valid && !empty;
  assign misp    = resolve && (ck_pred != i_ALU_Branch_Outcome);
  // A same-cycle pop frees a slot, so a push against a full queue still lands.
  assign push_ok = i_DEC_Is_Branch && (!full || resolve);

  always_comb begin
    spec_d       = spec_q;
    commit_d     = commit_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    push_we      = 1'b0;
    mispredict_d = misp;
    error_d      = error_q | (i_DEC_Is_Branch && full && !resolve)
                           | (i_ALU_Branch_Valid && empty);

    if (resolve) begin
      commit_d = {commit_q[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
    end

    if (i_Flush) begin
      spec_d   = commit_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (misp) begin
      // Younger entries are all wrong-path, so the queue is dropped wholesale.
      spec_d   = {ck_hist[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_ok) begin
        spec_d   = {spec_q[BPRED_WIDTH-2:0], i_Prediction};
        wr_ptr_d = wr_ptr_q + PW'(1);
        push_we  = 1'b1;
      end
      if (resolve) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(resolve);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      spec_q       <= '0;
      commit_q     <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      mispredict_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      spec_q       <= spec_d;
      commit_q     <= commit_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mispredict_q <= mispredict_d;
      error_q      <= error_d;
    end
  end

  // Entries are only read while counted valid, so the storage itself needs no reset.
  always_ff @(posedge i_Clk) begin
    if (push_we) begin
      entry_mem[wr_ptr_q] <= {spec_q, i_Prediction};
    end
  end

`ifdef SPEC_GHR_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (misp && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign o_Mispredict_Count = stat_q;
`endif

  assign o_Global_History = spec_q;
  assign o_Commit_History = commit_q;
  assign o_Count          = count_q;
  assign o_Full           = full;
  assign o_Mispredict     = mispredict_q;
  assign o_Error          = error_q;

endmodule

// File: tb/tb_spec_global_history_reg.sv
// Directed bench for spec_global_history_reg: expected state is queued per step and checked
// one time unit after the clock edge that should produce it.
module tb_spec_global_history_reg;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_DEC_Is_Branch;
  logic       i_Prediction;
  logic       i_ALU_Branch_Valid;
  logic       i_ALU_Branch_Outcome;
  logic       i_Flush;
  logic [8:0] o_Global_History;
  logic [8:0] o_Commit_History;
  logic       o_Full;
  logic       o_Mispredict;
  logic [2:0] o_Count;
  logic       o_Error;
`ifdef SPEC_GHR_STATS_EN
  logic [15:0] o_Mispredict_Count;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string      tag;
    logic [8:0] spec;
    logic [8:0] commit;
    int         cnt;
    logic       full;
    logic       misp;
    logic       err;
  } exp_t;

  exp_t expq[$];

  spec_global_history_reg #(.BPRED_WIDTH(9), .MAX_INFLIGHT(4)) dut (
    .i_Clk               (i_Clk),
    .i_Reset             (i_Reset),
    .i_DEC_Is_Branch     (i_DEC_Is_Branch),
    .i_Prediction        (i_Prediction),
    .i_ALU_Branch_Valid  (i_ALU_Branch_Valid),
    .i_ALU_Branch_Outcome(i_ALU_Branch_Outcome),
    .i_Flush             (i_Flush),
    .o_Global_History    (o_Global_History),
    .o_Commit_History    (o_Commit_History),
    .o_Full              (o_Full),
    .o_Mispredict        (o_Mispredict),
    .o_Count             (o_Count),
    .o_Error             (o_Error)
`ifdef SPEC_GHR_STATS_EN
    ,
    .o_Mispredict_Count  (o_Mispredict_Count)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_state(input string tag, input logic [8:0] es, input logic [8:0] ec,
                              input int ecnt, input logic ef, input logic em, input logic ee);
    exp_t e;
    e.tag = tag; e.spec = es; e.commit = ec; e.cnt = ecnt;
    e.full = ef; e.misp = em; e.err = ee;
    expq.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (expq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = expq.pop_front();
    chk({e.tag, ".spec"},   32'(o_Global_History), 32'(e.spec));
    chk({e.tag, ".commit"}, 32'(o_Commit_History), 32'(e.commit));
    chk({e.tag, ".count"},  32'(o_Count),          32'(e.cnt));
    chk({e.tag, ".full"},   32'(o_Full),           32'(e.full));
    chk({e.tag, ".misp"},   32'(o_Mispredict),     32'(e.misp));
    chk({e.tag, ".err"},    32'(o_Error),          32'(e.err));
    $display("step %-14s spec=%09b commit=%09b count=%0d full=%0b misp=%0b err=%0b",
             e.tag, o_Global_History, o_Commit_History, o_Count, o_Full, o_Mispredict, o_Error);
  endtask

  // Drive one cycle of stimulus, queue the state expected after the edge, then compare.
  task automatic step(input string tag, input logic br, input logic pred, input logic rv,
                      input logic outc, input logic fl, input logic [8:0] es,
                      input logic [8:0] ec, input int ecnt, input logic ef,
                      input logic em, input logic ee);
    expect_state(tag, es, ec, ecnt, ef, em, ee);
    i_DEC_Is_Branch      = br;
    i_Prediction         = pred;
    i_ALU_Branch_Valid   = rv;
    i_ALU_Branch_Outcome = outc;
    i_Flush              = fl;
    @(posedge i_Clk);
    #1;
    check_front();
  endtask

  initial begin
    i_Reset = 1'b1;
    i_DEC_Is_Branch = 1'b0; i_Prediction = 1'b0;
    i_ALU_Branch_Valid = 1'b0; i_ALU_Branch_Outcome = 1'b0; i_Flush = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1 i_Reset = 1'b0;
    expect_state("reset", 9'd0, 9'd0, 0, 1'b0, 1'b0, 1'b0);
    check_front();

    //    tag              br p  rv o  fl  spec    commit cnt full misp err
    step("push1",          1, 1, 0, 0, 0, 9'd1,   9'd0,  1, 0, 0, 0);
    step("push0",          1, 0, 0, 0, 0, 9'd2,   9'd0,  2, 0, 0, 0);
    step("push1b",         1, 1, 0, 0, 0, 9'd5,   9'd0,  3, 0, 0, 0);
    step("res_ok",         0, 0, 1, 1, 0, 9'd5,   9'd1,  2, 0, 0, 0);
    step("res_misp",       0, 0, 1, 1, 0, 9'd3,   9'd3,  0, 0, 1, 0);
    step("misp_done",      0, 0, 0, 0, 0, 9'd3,   9'd3,  0, 0, 0, 0);
    step("fill1",          1, 1, 0, 0, 0, 9'd7,   9'd3,  1, 0, 0, 0);
    step("fill2",          1, 1, 0, 0, 0, 9'd15,  9'd3,  2, 0, 0, 0);
    step("fill3",          1, 0, 0, 0, 0, 9'd30,  9'd3,  3, 0, 0, 0);
    step("fill4",          1, 1, 0, 0, 0, 9'd61,  9'd3,  4, 1, 0, 0);
    step("push_full",      1, 0, 0, 0, 0, 9'd61,  9'd3,  4, 1, 0, 1);
    step("push_res_full",  1, 0, 1, 1, 0, 9'd122, 9'd7,  4, 1, 0, 1);
    step("res_ok2",        0, 0, 1, 1, 0, 9'd122, 9'd15, 3, 0, 0, 1);
    step("res_misp2",      0, 0, 1, 1, 0, 9'd31,  9'd31, 0, 0, 1, 1);
    step("push_a",         1, 1, 0, 0, 0, 9'd63,  9'd31, 1, 0, 0, 1);
    step("push_b",         1, 1, 0, 0, 0, 9'd127, 9'd31, 2, 0, 0, 1);
    step("flush",          0, 0, 0, 0, 1, 9'd31,  9'd31, 0, 0, 0, 1);
    step("push_c",         1, 0, 0, 0, 0, 9'd62,  9'd31, 1, 0, 0, 1);
    step("push_d",         1, 1, 0, 0, 0, 9'd125, 9'd31, 2, 0, 0, 1);
    step("flush_res",      1, 1, 1, 0, 1, 9'd62,  9'd62, 0, 0, 0, 1);
    step("push_e",         1, 1, 0, 0, 0, 9'd125, 9'd62, 1, 0, 0, 1);

    // Asynchronous reset between edges must clear everything before the next edge.
    i_DEC_Is_Branch = 1'b0; i_ALU_Branch_Valid = 1'b0; i_Flush = 1'b0;
    #2 i_Reset = 1'b1;
    #1;
    expect_state("async_reset", 9'd0, 9'd0, 0, 1'b0, 1'b0, 1'b0);
    check_front();
    #2 i_Reset = 1'b0;

    step("res_empty",      0, 0, 1, 1, 0, 9'd0,   9'd0,  0, 0, 0, 1);
    step("push_f",         1, 1, 0, 0, 0, 9'd1,   9'd0,  1, 0, 0, 1);
    step("push_g",         1, 1, 0, 0, 0, 9'd3,   9'd0,  2, 0, 0, 1);
    step("res_ok3",        0, 0, 1, 1, 0, 9'd3,   9'd1,  1, 0, 0, 1);
    step("push_misp",      1, 0, 1, 0, 0, 9'd2,   9'd2,  0, 0, 1, 1);
    step("idle",           0, 0, 0, 0, 0, 9'd2,   9'd2,  0, 0, 0, 1);

`ifdef SPEC_GHR_STATS_EN
    chk("misp_count", 32'(o_Mispredict_Count), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
